// File: rtl/cluster_rate_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : cluster_rate_monitor
//  Description : Per-BX statistics accumulator for the strip cluster counter.
//                Integrates the registered cluster count and overflow flag
//                over a programmable window of BXs and publishes the window
//                sum (saturating), peak and overflow-BX count, a one-clock
//                valid strobe and a sticky overflow flag.
//  Revision    : 1.0  initial release
// ============================================================================
module cluster_rate_monitor #(
    parameter int SUM_BITS = 24,
    parameter int CNT_BITS = 11,
    parameter int WIN_BITS = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CNT_BITS-1:0] cnt_i,
    input  logic                overflow_i,
    input  logic [WIN_BITS-1:0] window_len_i,
    input  logic                clear_i,
    output logic [SUM_BITS-1:0] sum_o,
    output logic [CNT_BITS-1:0] peak_o,
    output logic [WIN_BITS-1:0] ovf_cnt_o,
    output logic                valid_o,
    output logic                ovf_latch_o
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    localparam logic [SUM_BITS-1:0] C_SUM_MAX = {SUM_BITS{1'b1}};
    localparam logic [WIN_BITS-1:0] C_WIN_ONE = {{(WIN_BITS-1){1'b0}}, 1'b1};

    // Registered state
    state_t                state_q,    state_d;
    logic [CNT_BITS-1:0]   cnt_q,      cnt_d;
    logic                  ovf_q,      ovf_d;
    logic [WIN_BITS-1:0]   win_len_q,  win_len_d;
    logic [WIN_BITS-1:0]   bx_q,       bx_d;
    logic [SUM_BITS-1:0]   acc_sum_q,  acc_sum_d;
    logic [CNT_BITS-1:0]   acc_peak_q, acc_peak_d;
    logic [WIN_BITS-1:0]   acc_ovf_q,  acc_ovf_d;
    logic [SUM_BITS-1:0]   sum_q,      sum_d;
    logic [CNT_BITS-1:0]   peak_q,     peak_d;
    logic [WIN_BITS-1:0]   ovf_cnt_q,  ovf_cnt_d;
    logic                  valid_q,    valid_d;
    logic                  latch_q,    latch_d;

    // Accumulator candidates that include the current registered sample
    logic [SUM_BITS:0]     w_sum_ext;
    logic [SUM_BITS-1:0]   w_sum_next;
    logic [CNT_BITS-1:0]   w_peak_next;
    logic [WIN_BITS-1:0]   w_ovf_next;
    logic                  w_last_bx;
    logic                  w_len_nonzero;

    // Saturating sum, running max and overflow count for this edge's sample
    always_comb begin
        w_sum_ext     = {1'b0, acc_sum_q} + {{(SUM_BITS+1-CNT_BITS){1'b0}}, cnt_q};
        w_sum_next    = w_sum_ext[SUM_BITS] ? C_SUM_MAX : w_sum_ext[SUM_BITS-1:0];
        w_peak_next   = (cnt_q > acc_peak_q) ? cnt_q : acc_peak_q;
        w_ovf_next    = acc_ovf_q + {{(WIN_BITS-1){1'b0}}, ovf_q};
        w_last_bx     = (bx_q == (win_len_q - C_WIN_ONE));
        w_len_nonzero = |window_len_i;
    end

    // Next-state and output logic; clear_i overrides every set/accumulate path
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_i;
        ovf_d      = overflow_i;
        win_len_d  = win_len_q;
        bx_d       = bx_q;
        acc_sum_d  = acc_sum_q;
        acc_peak_d = acc_peak_q;
        acc_ovf_d  = acc_ovf_q;
        sum_d      = sum_q;
        peak_d     = peak_q;
        ovf_cnt_d  = ovf_cnt_q;
        valid_d    = 1'b0;
        latch_d    = latch_q | ovf_q;

        if (clear_i) begin
            // Drop the current window and this edge's sample, keep outputs
            latch_d    = 1'b0;
            acc_sum_d  = '0;
            acc_peak_d = '0;
            acc_ovf_d  = '0;
            bx_d       = '0;
            win_len_d  = window_len_i;
            state_d    = w_len_nonzero ? ST_ACCUM : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    acc_sum_d  = '0;
                    acc_peak_d = '0;
                    acc_ovf_d  = '0;
                    if (w_len_nonzero) begin
                        win_len_d = window_len_i;
                        bx_d      = '0;
                        state_d   = ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (w_last_bx) begin
                        // Window boundary: publish and restart with a fresh length
                        sum_d      = w_sum_next;
                        peak_d     = w_peak_next;
                        ovf_cnt_d  = w_ovf_next;
                        valid_d    = 1'b1;
                        acc_sum_d  = '0;
                        acc_peak_d = '0;
                        acc_ovf_d  = '0;
                        bx_d       = '0;
                        win_len_d  = window_len_i;
                        state_d    = w_len_nonzero ? ST_ACCUM : ST_IDLE;
                    end else begin
                        acc_sum_d  = w_sum_next;
                        acc_peak_d = w_peak_next;
                        acc_ovf_d  = w_ovf_next;
                        bx_d       = bx_q + C_WIN_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State register with asynchronous reset to the idle, all-zero state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            win_len_q  <= '0;
            bx_q       <= '0;
            acc_sum_q  <= '0;
            acc_peak_q <= '0;
            acc_ovf_q  <= '0;
            sum_q      <= '0;
            peak_q     <= '0;
            ovf_cnt_q  <= '0;
            valid_q    <= 1'b0;
            latch_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            win_len_q  <= win_len_d;
            bx_q       <= bx_d;
            acc_sum_q  <= acc_sum_d;
            acc_peak_q <= acc_peak_d;
            acc_ovf_q  <= acc_ovf_d;
            sum_q      <= sum_d;
            peak_q     <= peak_d;
            ovf_cnt_q  <= ovf_cnt_d;
            valid_q    <= valid_d;
            latch_q    <= latch_d;
        end
    end

    assign sum_o       = sum_q;
    assign peak_o      = peak_q;
    assign ovf_cnt_o   = ovf_cnt_q;
    assign valid_o     = valid_q;
    assign ovf_latch_o = latch_q;

endmodule
`default_nettype wire

// File: tb/tb_cluster_rate_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cluster_rate_monitor
//  Description : Self-checking bench for cluster_rate_monitor. A window
//                collector model (sample list semantics, unbounded sum
//                clipped at publish) predicts every output each clock.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cluster_rate_monitor;

    localparam int  SUM_BITS = 24;
    localparam int  CNT_BITS = 11;
    localparam int  WIN_BITS = 16;
    localparam longint SUM_MAX = (64'd1 << SUM_BITS) - 1;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [CNT_BITS-1:0] cnt_i = '0;
    logic                overflow_i = 1'b0;
    logic [WIN_BITS-1:0] window_len_i = '0;
    logic                clear_i = 1'b0;
    logic [SUM_BITS-1:0] sum_o;
    logic [CNT_BITS-1:0] peak_o;
    logic [WIN_BITS-1:0] ovf_cnt_o;
    logic                valid_o;
    logic                ovf_latch_o;

    int n_checks = 0;
    int n_fail   = 0;

    cluster_rate_monitor #(
        .SUM_BITS(SUM_BITS),
        .CNT_BITS(CNT_BITS),
        .WIN_BITS(WIN_BITS)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cnt_i        (cnt_i),
        .overflow_i   (overflow_i),
        .window_len_i (window_len_i),
        .clear_i      (clear_i),
        .sum_o        (sum_o),
        .peak_o       (peak_o),
        .ovf_cnt_o    (ovf_cnt_o),
        .valid_o      (valid_o),
        .ovf_latch_o  (ovf_latch_o)
    );

    always #5 clock = ~clock;

    // Reference model state
    bit                  m_active;
    int                  m_len, m_n;
    longint              m_sum;
    int                  m_peak, m_ovf;
    int                  m_pc;
    bit                  m_po;
    bit                  m_latch;
    logic [SUM_BITS-1:0] exp_sum;
    logic [CNT_BITS-1:0] exp_peak;
    logic [WIN_BITS-1:0] exp_ovf;
    bit                  exp_valid;

    task automatic model_reset();
        m_active = 0; m_len = 0; m_n = 0; m_sum = 0; m_peak = 0; m_ovf = 0;
        m_pc = 0; m_po = 0; m_latch = 0;
        exp_sum = '0; exp_peak = '0; exp_ovf = '0; exp_valid = 0;
    endtask

    task automatic drop_window();
        m_n = 0; m_sum = 0; m_peak = 0; m_ovf = 0;
    endtask

    // One clock: the model consumes the inputs presented before the edge
    task automatic tick();
        @(posedge clock);
        if (reset) begin
            model_reset();
        end else begin
            int rc;
            bit ro;
            rc = m_pc;
            ro = m_po;
            exp_valid = 0;
            if (clear_i) begin
                m_latch  = 0;
                drop_window();
                m_len    = int'(window_len_i);
                m_active = (window_len_i != 0);
            end else begin
                if (ro) m_latch = 1;
                if (!m_active) begin
                    if (window_len_i != 0) begin
                        m_len = int'(window_len_i); m_n = 0; m_active = 1;
                    end
                end else begin
                    m_sum += rc;
                    if (rc > m_peak) m_peak = rc;
                    m_ovf += int'(ro);
                    m_n++;
                    if (m_n == m_len) begin
                        exp_sum   = (m_sum > SUM_MAX) ? SUM_MAX[SUM_BITS-1:0] : m_sum[SUM_BITS-1:0];
                        exp_peak  = m_peak[CNT_BITS-1:0];
                        exp_ovf   = m_ovf[WIN_BITS-1:0];
                        exp_valid = 1;
                        drop_window();
                        m_len    = int'(window_len_i);
                        m_active = (window_len_i != 0);
                    end
                end
            end
            m_pc = int'(cnt_i);
            m_po = overflow_i;
        end
        #1;
    endtask

    // Let the current window finish with length 0 so the DUT returns to idle
    task automatic drain();
        int k;
        window_len_i = '0; clear_i = 0; overflow_i = 0;
        k = 0;
        while (m_active && k < 64) begin tick(); k++; end
        tick();
        n_checks++;
        if (m_active || valid_o !== 1'b0)
            begin n_fail++; $display("FAIL drain: got valid=%0b active=%0b want valid=0 active=0", valid_o, m_active); end
    endtask

    task automatic test_reset();
        tick(); tick();
        n_checks++;
        if ({sum_o, peak_o, ovf_cnt_o, valid_o, ovf_latch_o} !== '0)
            begin n_fail++; $display("FAIL reset: got sum=%0h peak=%0h ovf=%0h v=%0b l=%0b want all 0", sum_o, peak_o, ovf_cnt_o, valid_o, ovf_latch_o); end
        reset = 0;
        tick();
    endtask

    task automatic test_basic();
        window_len_i = 16'd4; overflow_i = 0;
        for (int i = 0; i < 14; i++) begin
            cnt_i = (i < 4) ? CNT_BITS'(i + 1) : CNT_BITS'($urandom_range(0, 2047));
            tick();
            n_checks++;
            if ({sum_o, peak_o, ovf_cnt_o, valid_o, ovf_latch_o} !== {exp_sum, exp_peak, exp_ovf, exp_valid, m_latch})
                begin n_fail++; $display("FAIL basic[%0d]: got sum=%0h peak=%0h ovf=%0h v=%0b l=%0b want sum=%0h peak=%0h ovf=%0h v=%0b l=%0b", i, sum_o, peak_o, ovf_cnt_o, valid_o, ovf_latch_o, exp_sum, exp_peak, exp_ovf, exp_valid, m_latch); end
            if (i == 3) begin
                n_checks++;
                if (valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_early: got valid=%0b want 0", valid_o); end
            end
            if (i == 4) begin
                n_checks++;
                if ({valid_o, sum_o, peak_o, ovf_cnt_o} !== {1'b1, 24'd10, 11'd4, 16'd0})
                    begin n_fail++; $display("FAIL basic_window: got v=%0b sum=%0d peak=%0d ovf=%0d want v=1 sum=10 peak=4 ovf=0", valid_o, sum_o, peak_o, ovf_cnt_o); end
            end
        end
        drain();
    endtask

    task automatic test_overflow();
        window_len_i = 16'd8;
        for (int i = 0; i < 26; i++) begin
            cnt_i      = CNT_BITS'($urandom_range(0, 300));
            overflow_i = (i == 1 || i == 4 || i == 6);
            if (i == 24) clear_i = 1; else clear_i = 0;
            tick();
            n_checks++;
            if ({sum_o, peak_o, ovf_cnt_o, valid_o, ovf_latch_o} !== {exp_sum, exp_peak, exp_ovf, exp_valid, m_latch})
                begin n_fail++; $display("FAIL overflow[%0d]: got sum=%0h peak=%0h ovf=%0h v=%0b l=%0b want sum=%0h peak=%0h ovf=%0h v=%0b l=%0b", i, sum_o, peak_o, ovf_cnt_o, valid_o, ovf_latch_o, exp_sum, exp_peak, exp_ovf, exp_valid, m_latch); end
            if (i == 8) begin
                n_checks++;
                if ({valid_o, ovf_cnt_o} !== {1'b1, 16'd3})
                    begin n_fail++; $display("FAIL overflow_count: got v=%0b ovf=%0d want v=1 ovf=3", valid_o, ovf_cnt_o); end
            end
            if (i == 23 || i == 24) begin
                n_checks++;
                if (ovf_latch_o !== ((i == 23) ? 1'b1 : 1'b0))
                    begin n_fail++; $display("FAIL overflow_sticky[%0d]: got latch=%0b want %0b", i, ovf_latch_o, (i == 23)); end
            end
        end
        clear_i = 0;
        drain();
    endtask

    task automatic test_saturation();
        cnt_i = 11'd2047; overflow_i = 0;
        for (int i = 0; i <= 8200; i++) begin
            window_len_i = (i >= 8100) ? 16'd0 : 16'd8200;
            tick();
            if (valid_o || exp_valid) begin
                n_checks++;
                if ({sum_o, peak_o, ovf_cnt_o, valid_o} !== {exp_sum, exp_peak, exp_ovf, exp_valid})
                    begin n_fail++; $display("FAIL saturation[%0d]: got sum=%0h peak=%0h ovf=%0h v=%0b want sum=%0h peak=%0h ovf=%0h v=%0b", i, sum_o, peak_o, ovf_cnt_o, valid_o, exp_sum, exp_peak, exp_ovf, exp_valid); end
            end
        end
        n_checks++;
        if ({sum_o, peak_o, ovf_cnt_o} !== {24'hFFFFFF, 11'd2047, 16'd0})
            begin n_fail++; $display("FAIL saturation_value: got sum=%0h peak=%0d ovf=%0d want sum=ffffff peak=2047 ovf=0", sum_o, peak_o, ovf_cnt_o); end
        drain();
    endtask

    task automatic test_len_change();
        overflow_i = 0;
        for (int i = 0; i < 24; i++) begin
            window_len_i = (i < 2) ? 16'd4 : (i < 14) ? 16'd2 : 16'd0;
            cnt_i = CNT_BITS'(i + 1);
            tick();
            n_checks++;
            if ({sum_o, peak_o, ovf_cnt_o, valid_o, ovf_latch_o} !== {exp_sum, exp_peak, exp_ovf, exp_valid, m_latch})
                begin n_fail++; $display("FAIL len_change[%0d]: got sum=%0h peak=%0h v=%0b want sum=%0h peak=%0h v=%0b", i, sum_o, peak_o, valid_o, exp_sum, exp_peak, exp_valid); end
        end
        n_checks++;
        if ({valid_o, sum_o, peak_o} !== {1'b0, 24'd27, 11'd14})
            begin n_fail++; $display("FAIL len_change_final: got v=%0b sum=%0d peak=%0d want v=0 sum=27 peak=14", valid_o, sum_o, peak_o); end
        drain();
    endtask

    task automatic test_clear_window_end();
        overflow_i = 0;
        for (int i = 0; i < 20; i++) begin
            window_len_i = (i < 13) ? 16'd4 : 16'd0;
            cnt_i   = (i < 4) ? 11'd3 : 11'd5;
            clear_i = (i == 8);
            tick();
            n_checks++;
            if ({sum_o, peak_o, ovf_cnt_o, valid_o, ovf_latch_o} !== {exp_sum, exp_peak, exp_ovf, exp_valid, m_latch})
                begin n_fail++; $display("FAIL clear_end[%0d]: got sum=%0h peak=%0h v=%0b want sum=%0h peak=%0h v=%0b", i, sum_o, peak_o, valid_o, exp_sum, exp_peak, exp_valid); end
            if (i == 8 || i == 12) begin
                n_checks++;
                if ({valid_o, sum_o} !== ((i == 8) ? {1'b0, 24'd12} : {1'b1, 24'd20}))
                    begin n_fail++; $display("FAIL clear_end_value[%0d]: got v=%0b sum=%0d want %s", i, valid_o, sum_o, (i == 8) ? "v=0 sum=12" : "v=1 sum=20"); end
            end
        end
        clear_i = 0;
        drain();
    endtask

    task automatic test_random();
        window_len_i = 16'd3;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 15) == 0) window_len_i = WIN_BITS'($urandom_range(0, 6));
            if (i >= 460) window_len_i = '0;
            cnt_i      = CNT_BITS'($urandom_range(0, 2047));
            overflow_i = ($urandom_range(0, 7) == 0);
            clear_i    = ($urandom_range(0, 39) == 0);
            tick();
            n_checks++;
            if ({sum_o, peak_o, ovf_cnt_o, valid_o, ovf_latch_o} !== {exp_sum, exp_peak, exp_ovf, exp_valid, m_latch})
                begin n_fail++; $display("FAIL random[%0d]: got sum=%0h peak=%0h ovf=%0h v=%0b l=%0b want sum=%0h peak=%0h ovf=%0h v=%0b l=%0b", i, sum_o, peak_o, ovf_cnt_o, valid_o, ovf_latch_o, exp_sum, exp_peak, exp_ovf, exp_valid, m_latch); end
        end
        clear_i = 0;
        drain();
    endtask

    task automatic test_reset_mid();
        window_len_i = 16'd4;
        cnt_i = 11'd7;
        for (int i = 0; i < 3; i++) begin
            overflow_i = (i == 0);
            tick();
        end
        overflow_i = 0;
        reset = 1;
        #1;
        n_checks++;
        if ({sum_o, peak_o, ovf_cnt_o, valid_o, ovf_latch_o} !== '0)
            begin n_fail++; $display("FAIL reset_mid: got sum=%0h peak=%0h ovf=%0h v=%0b l=%0b want all 0", sum_o, peak_o, ovf_cnt_o, valid_o, ovf_latch_o); end
        model_reset();
        cnt_i = 11'd1;
        tick(); tick();
        reset = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if ({sum_o, peak_o, ovf_cnt_o, valid_o, ovf_latch_o} !== {exp_sum, exp_peak, exp_ovf, exp_valid, m_latch})
                begin n_fail++; $display("FAIL reset_mid[%0d]: got sum=%0h peak=%0h v=%0b l=%0b want sum=%0h peak=%0h v=%0b l=%0b", i, sum_o, peak_o, valid_o, ovf_latch_o, exp_sum, exp_peak, exp_valid, m_latch); end
            if (i == 4) begin
                n_checks++;
                if ({valid_o, sum_o, peak_o} !== {1'b1, 24'd4, 11'd1})
                    begin n_fail++; $display("FAIL reset_mid_window: got v=%0b sum=%0d peak=%0d want v=1 sum=4 peak=1", valid_o, sum_o, peak_o); end
            end
        end
        drain();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_overflow();
        test_saturation();
        test_len_change();
        test_clear_window_end();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cluster_rate_monitor.md
Name: cluster_rate_monitor

Overview:
Per-BX statistics accumulator sitting directly downstream of the 768-strip cluster counter. Consumes the per-BX cluster count and overflow flag every clock, integrates over a programmable window of BXs, and publishes window sum, window peak and overflow-BX count, plus a sticky overflow flag. Outputs feed the slow-control register file and the readout rate-throttling logic.

Parameters:
SUM_BITS, 24, width of window sum; saturates at 2^SUM_BITS-1
CNT_BITS, 11, width of incoming per-BX cluster count
WIN_BITS, 16, width of window length and overflow-BX counter

Ports:
clock  in  1  fabric clock, 40 MHz BX-synchronous
reset  in  1  asynchronous, active-high
cnt_i  in  CNT_BITS  cluster count for current BX, valid every clock
overflow_i  in  1  cluster-overflow flag for current BX
window_len_i  in  WIN_BITS  BXs per window; 0 = monitor disabled
clear_i  in  1  synchronous clear of sticky flag and current window
sum_o  out  SUM_BITS  sum of cnt_i over last completed window, saturating
peak_o  out  CNT_BITS  max cnt_i in last completed window
ovf_cnt_o  out  WIN_BITS  BXs with overflow_i=1 in last completed window
valid_o  out  1  one-clock strobe, outputs just updated
ovf_latch_o  out  1  sticky: any overflow_i since reset/clear

Behaviour:
- Reset (async, active-high): all outputs 0; accumulators, BX counter, input regs, latched window length 0; state IDLE.
- Input stage: cnt_i, overflow_i registered once (cnt_r, ovf_r) every clock regardless of state.
- States: IDLE, ACCUM.
- IDLE: accumulators held 0, valid_o 0, published outputs hold. When window_len_i != 0: latch win_len <= window_len_i, bx <= 0, go ACCUM next clock. First sample accumulated = cnt_r at the first ACCUM edge.
- ACCUM, each edge: acc_sum += cnt_r (saturating at SUM_BITS all-ones), acc_peak = max(acc_peak, cnt_r), acc_ovf += ovf_r.
- Window end: at edge where bx == win_len-1: sum_o/peak_o/ovf_cnt_o <= values including that edge's sample; valid_o <= 1 for exactly one clock; accumulators <= 0; bx <= 0; win_len re-latched from window_len_i. Otherwise bx <= bx+1, valid_o <= 0.
- Latency: sample on cnt_i before edge E0 -> cnt_r at E0 -> included at E1; for the last sample of a window, outputs and valid_o visible after E1 (2 edges).
- window_len_i change mid-window: ignored until next window boundary. window_len_i = 0 at a boundary: publish that window, then IDLE. window_len_i = 1: valid_o high every clock, sum_o = peak_o = previous cnt_r.
- acc_ovf cannot exceed win_len, no saturation needed. Peak never saturates.
- ovf_latch_o: set on any edge with ovf_r = 1 (any state); cleared only by reset or clear_i.
- clear_i (sync, priority over all set/accumulate): ovf_latch_o <= 0, accumulators <= 0, bx <= 0, win_len re-latched; that edge's sample discarded; no publish even if coincident with window end; sum_o/peak_o/ovf_cnt_o hold; valid_o <= 0.
- Reset asserted mid-window: immediate return to reset values; no partial publish.

Test Plan:
- window_len_i=4, cnt_i=1,2,3,4, overflow_i=0 -> single valid_o pulse 2 clocks after cnt=4 presented; sum_o=10, peak_o=4, ovf_cnt_o=0; next window continues with no gap BX.
- window_len_i=8, overflow_i high on 3 of 8 BXs -> ovf_cnt_o=3, ovf_latch_o=1 from the clock after first overflow and stays 1 across later clean windows until clear_i.
- window_len_i=16'hFFFF, cnt_i=2047 constant -> sum_o=24'hFFFFFF (saturated), peak_o=2047, ovf_cnt_o unchanged by count.
- window_len_i 4->2 mid-window -> current window still publishes after 4 BXs; following windows publish every 2 BXs; then 0 -> one last publish, IDLE, valid_o stays 0, outputs hold.
- clear_i on window-end edge (window_len_i=4, cnt=5 each) -> no valid_o, outputs hold previous values, next window of 4 publishes sum_o=20.
- reset pulsed mid-window (e.g. 2 of 4 samples in) -> all outputs 0 immediately; after release, first published window contains only post-reset samples.
